// File: rtl/period_gen.sv
// Burst square-wave generator: n_cyc periods of prd milliseconds each,
// timed from a 1 ms tick derived from the system clock.
module period_gen #(
  parameter int CLK_MS_COUNT = 50000,
  parameter int N_W          = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [9:0]     prd,
  input  logic [N_W-1:0] n_cyc,
  output logic           ready,
  output logic           done_tick,
  output logic           so
);

  typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW, S_DONE} state_t;

  localparam logic [15:0] T_LAST = 16'(CLK_MS_COUNT - 1);

  state_t         state_reg, state_next;
  logic [15:0]    t_reg, t_next;
  logic [9:0]     m_reg, m_next;
  logic [N_W-1:0] n_reg, n_next;
  logic [9:0]     h_reg, h_next;
  logic [9:0]     l_reg, l_next;
  logic           so_reg, so_next;
  logic [9:0]     p_eff;
  logic           t_wrap;

  // Periods below 2 ms cannot be split into two non-empty phases.
  function automatic logic [9:0] eff_period(input logic [9:0] p);
    return (p < 10'd2) ? 10'd2 : p;
  endfunction

  assign p_eff  = eff_period(prd);
  assign t_wrap = (t_reg == T_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_IDLE;
      t_reg     <= '0;
      m_reg     <= '0;
      n_reg     <= '0;
      h_reg     <= '0;
      l_reg     <= '0;
      so_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      t_reg     <= t_next;
      m_reg     <= m_next;
      n_reg     <= n_next;
      h_reg     <= h_next;
      l_reg     <= l_next;
      so_reg    <= so_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    t_next     = t_reg;
    m_next     = m_reg;
    n_next     = n_reg;
    h_next     = h_reg;
    l_next     = l_reg;
    so_next    = so_reg;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          h_next = p_eff - (p_eff >> 1);
          l_next = p_eff >> 1;
          n_next = n_cyc;
          t_next = '0;
          m_next = '0;
          if (n_cyc == '0) begin
            state_next = S_DONE;
          end else begin
            state_next = S_HIGH;
            so_next    = 1'b1;
          end
        end
      end
      S_HIGH: begin
        t_next = t_wrap ? 16'd0 : t_reg + 16'd1;
        if (t_wrap) begin
          if (m_reg == h_reg - 10'd1) begin
            m_next     = '0;
            state_next = S_LOW;
            so_next    = 1'b0;
          end else begin
            m_next = m_reg + 10'd1;
          end
        end
      end
      S_LOW: begin
        t_next = t_wrap ? 16'd0 : t_reg + 16'd1;
        if (t_wrap) begin
          if (m_reg == l_reg - 10'd1) begin
            m_next = '0;
            n_next = n_reg - N_W'(1);
            // Next high phase starts on this same edge, keeping periods contiguous.
            if (n_reg == N_W'(1)) begin
              state_next = S_DONE;
            end else begin
              state_next = S_HIGH;
              so_next    = 1'b1;
            end
          end else begin
            m_next = m_reg + 10'd1;
          end
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign ready     = (state_reg == S_IDLE);
  assign done_tick = (state_reg == S_DONE);
  assign so        = so_reg;

endmodule
